riscv_data_mem: RTL
===================

Name: riscv_data_mem

Overview:
- Parametrised, byte-addressable data memory for the RISC-V core's MEM stage.
- Supports all RV32I load/store sizes (funct3 encoding), with sign/zero extension, byte-lane writes and alignment/range error detection.
- Valid/ready request port and single-cycle response pulse; configurable wait-state latency, so pipelined and multi-cycle cores share one block.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; legal word index 0..DEPTH_WORDS-1.
- ADDR_W, 32, request byte-address width.
- WAIT_CYCLES, 0, extra cycles between acceptance and response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others invalid.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected: misaligned, out of range or invalid size.

Behaviour:
- Handshake and state machine:
  - Request accepted on a rising edge where req_valid && req_ready.
  - req_ready = (state==IDLE) || (state==RESP).
  - There is no response backpressure.
  - FSM states are IDLE, WAIT and RESP.
  - IDLE/RESP with accept: go to WAIT (load cnt=WAIT_CYCLES) if WAIT_CYCLES>0, else go to RESP.
  - IDLE/RESP with no accept: go to IDLE.
  - WAIT: decrement cnt each cycle; go to RESP when cnt==1.
- Response timing:
  - rsp_valid=1 exactly while state==RESP.
  - Latency is WAIT_CYCLES+1 cycles from accept edge to rsp_valid high.
  - With WAIT_CYCLES=0, throughput is 1 request/cycle, back-to-back.
- Error checks, evaluated at accept:
  - req_size 011/110/111 is invalid.
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - Word index addr[ADDR_W-1:2] >= DEPTH_WORDS is out of range.
  - On any error: no write occurs, rsp_err=1, rsp_rdata=0.
- Stores (commit at the accept edge):
  - SB writes wdata[7:0] into lane addr[1:0].
  - SH writes wdata[15:0] into lane addr[1] (bytes 1:0 or 3:2).
  - SW writes the full word.
  - Unselected bytes are unchanged.
  - Store response: rsp_rdata=0, rsp_err=0.
- Loads:
  - Word read at the accept edge; lane select and extension registered into a result register.
  - rsp_rdata holds that result through RESP.
  - B/H sign-extend; BU/HU zero-extend; W returns the word.
- Hazards: a load accepted the cycle after a store to the same word returns the updated data. Stores commit at accept, so no forwarding path is needed.
- Output hold: rsp_rdata/rsp_err hold their last value outside RESP; only rsp_valid qualifies them.
- Little-endian: byte 0 is bits 7:0.
- Reset (rst=0, async):
  - state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready goes to 1 once state=IDLE.
  - Memory array is NOT cleared; contents are undefined until written.
  - A pending response is dropped; a store already committed persists.
- Inputs are sampled only on accept; changes while req_ready=0 are ignored.

Test Plan:
- Reset then SW addr 0x10 data 0xDEADBEEF, LW 0x10 -> rsp_valid 1 cycle after accept, rdata 0xDEADBEEF, err 0.
- After the SW above: SB 0x11 data 0x55, then LB 0x11 -> 0x00000055; LW 0x10 -> 0xDEAD55EF.
- Sign/zero extension: SH 0x22 data 0x8001, then:
  - LH 0x22 -> 0xFFFF8001.
  - LHU 0x22 -> 0x00008001.
  - LB 0x23 -> 0xFFFFFF80.
  - LBU 0x23 -> 0x00000080.
- Errors:
  - LW 0x13 -> err 1, rdata 0.
  - SH 0x21 -> err 1, memory unchanged.
  - LW 4*DEPTH_WORDS -> err 1.
  - size 011 -> err 1.
- WAIT_CYCLES=3:
  - req_ready low for 3 cycles after accept; rsp_valid high 4 cycles after accept.
  - rst pulse during WAIT -> no rsp_valid; a subsequent LW returns the committed store data.
- WAIT_CYCLES=0, back-to-back SW 0x40 0x12345678 then LW 0x40 on consecutive cycles -> two consecutive rsp_valid pulses, second rdata 0x12345678.

Source files
------------

// File: rtl/riscv_data_mem.sv
// riscv_data_mem: byte-addressable RV32I data memory with valid/ready request and one-cycle response pulse
// Ports: clk/rst (async active-low); req_valid/req_ready/req_we/req_addr/req_size/req_wdata request;
// rsp_valid pulse with rsp_rdata (load result, 0 for stores/errors) and rsp_err (misaligned/out of range/bad size).
module riscv_data_mem #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic acc, bad_size, misal, oor, err;
  logic [ADDR_W-3:0] widx;
  logic [IW-1:0] mi;
  logic [31:0] word, wd, ld;
  logic [3:0] be;
  logic [7:0] b;
  logic [15:0] h;
  assign req_ready = state_q != WAIT;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  always_comb begin
    acc = req_valid && req_ready;
    widx = req_addr[ADDR_W-1:2];
    mi = widx[IW-1:0];
    bad_size = req_size == 3'b011 || req_size[2:1] == 2'b11;
    misal = (req_size[1:0] == 2'b01 && req_addr[0]) || (req_size[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    oor = widx >= (ADDR_W-2)'(DEPTH_WORDS);
    err = bad_size || misal || oor;
    word = mem[mi];
    b = 8'(word >> {req_addr[1:0], 3'b000});
    h = req_addr[1] ? word[31:16] : word[15:0];
    // funct3[2] selects zero extension, funct3[1:0] the access size
    ld = req_size[1] ? word : req_size[0] ? {{16{h[15] & ~req_size[2]}}, h} : {{24{b[7] & ~req_size[2]}}, b};
    be = req_size[1] ? 4'hf : req_size[0] ? (req_addr[1] ? 4'hc : 4'h3) : 4'b0001 << req_addr[1:0];
    wd = req_size[1] ? req_wdata : req_size[0] ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
    state_d = acc ? (WAIT_CYCLES > 0 ? WAIT : RESP) : state_q == WAIT ? (cnt_q == 4'd1 ? RESP : WAIT) : IDLE;
    cnt_d = acc ? 4'(WAIT_CYCLES) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    err_d = acc ? err : err_q;
    rdata_d = acc ? (err || req_we ? 32'h0 : ld) : rdata_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      rdata_q <= 32'h0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  // stores commit at the accept edge, so a following load sees them without forwarding
  always_ff @(posedge clk) begin
    if (acc && req_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[mi][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule
